// File: rtl/bnn_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bnn_pkg : constants and layer encodings shared by the binary conv datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
package bnn_pkg;

  localparam int W1    = 28;
  localparam int W2    = 12;
  localparam int K     = 3;
  localparam int CNT_W = 5;

  typedef enum logic {
    LAYER1 = 1'b0,
    LAYER2 = 1'b1
  } layer_e;

  // Frame width for the selected layer; widths may be overridden per instance
  function automatic logic [CNT_W-1:0] ni_of(input logic state,
                                             input int   w1 = W1,
                                             input int   w2 = W2);
    return (layer_e'(state) == LAYER2) ? CNT_W'(w2) : CNT_W'(w1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin_window_gen_line_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_fifo : 1-bit circular line buffer, runtime length, read-old-then-write
// Revision: 1.0
// ---------------------------------------------------------------------------
module line_fifo
  import bnn_pkg::*;
#(
  parameter int MAX_W = 28
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             din_i,
  output logic             dout_o
);

  logic [MAX_W-1:0] mem_q;
  logic [CNT_W-1:0] ptr_q;
  logic [CNT_W-1:0] ptr_d;

  // Old content at the pointer is what gets delayed by exactly len_i beats
  assign dout_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = (ptr_q == len_i - 1'b1) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i && !clr_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bin_window_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin_window_gen : 3-row sliding column source for the binary 3x3 conv engine
// Revision: 1.0
// ---------------------------------------------------------------------------
module bin_window_gen
  import bnn_pkg::*;
#(
  parameter int W1    = 28,
  parameter int W2    = 12,
  parameter int MAX_W = 28
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             state,
  input  logic             din_valid,
  input  logic             din,
  output logic [2:0]       taps,
  output logic             tvalid,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             frame_done
);

  logic             start_q;
  logic [CNT_W-1:0] ni_q, ni_d;
  logic [CNT_W-1:0] col_in_q, col_in_d;
  logic [CNT_W-1:0] row_in_q, row_in_d;
  logic [2:0]       taps_q, taps_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             tvalid_q, tvalid_d;
  logic             fd_q, fd_d;

  logic w_acc;
  logic w_col_last;
  logic w_row_last;
  logic w_l0_rd;
  logic w_l1_rd;

  // A beat arriving on the start rising edge already uses the new width
  assign ni_d       = (start && !start_q) ? ni_of(state, W1, W2) : ni_q;
  assign w_acc      = start & din_valid;
  assign w_col_last = (col_in_q == ni_d - 1'b1);
  assign w_row_last = (row_in_q == ni_d - 1'b1);

  line_fifo #(.MAX_W(MAX_W)) u_l0 (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (!start),
    .en_i   (w_acc),
    .len_i  (ni_d),
    .din_i  (din),
    .dout_o (w_l0_rd)
  );

  line_fifo #(.MAX_W(MAX_W)) u_l1 (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (!start),
    .en_i   (w_acc),
    .len_i  (ni_d),
    .din_i  (w_l0_rd),
    .dout_o (w_l1_rd)
  );

  always_comb begin
    col_in_d = col_in_q;
    row_in_d = row_in_q;
    taps_d   = taps_q;
    col_d    = col_q;
    row_d    = row_q;
    tvalid_d = 1'b0;
    fd_d     = 1'b0;
    if (!start) begin
      col_in_d = '0;
      row_in_d = '0;
      taps_d   = '0;
      col_d    = '0;
      row_d    = '0;
    end else if (din_valid) begin
      taps_d   = {w_l1_rd, w_l0_rd, din};
      col_d    = col_in_q;
      row_d    = row_in_q;
      tvalid_d = (row_in_q >= CNT_W'(2));
      fd_d     = w_col_last & w_row_last;
      if (w_col_last) begin
        col_in_d = '0;
        row_in_d = w_row_last ? '0 : row_in_q + 1'b1;
      end else begin
        col_in_d = col_in_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q  <= 1'b0;
      ni_q     <= CNT_W'(W1);
      col_in_q <= '0;
      row_in_q <= '0;
      taps_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      tvalid_q <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      start_q  <= start;
      ni_q     <= ni_d;
      col_in_q <= col_in_d;
      row_in_q <= row_in_d;
      taps_q   <= taps_d;
      col_q    <= col_d;
      row_q    <= row_d;
      tvalid_q <= tvalid_d;
      fd_q     <= fd_d;
    end
  end

  assign taps       = taps_q;
  assign tvalid     = tvalid_q;
  assign col        = col_q;
  assign row        = row_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_window_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bin_window_gen : randomized bench with a row-delay queue reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bin_window_gen;

  localparam int NI1 = 28;
  localparam int NI2 = 12;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic       state = 1'b0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic [2:0] taps;
  logic       tvalid;
  logic [4:0] col;
  logic [4:0] row;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // reference: taps are the pixel now, one row ago and two rows ago
  int   m_ni = NI1;
  int   m_n  = 0;
  bit   m_hist[$];
  logic [2:0] e_taps, e_mask;
  int   e_col, e_row;
  bit   e_tv, e_fd;

  bin_window_gen #(.W1(28), .W2(12), .MAX_W(28)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .state      (state),
    .din_valid  (din_valid),
    .din        (din),
    .taps       (taps),
    .tvalid     (tvalid),
    .col        (col),
    .row        (row),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept(input bit d);
    int sz;
    sz     = m_hist.size();
    e_mask = 3'b001;
    e_taps = {2'b00, d};
    if (sz >= m_ni) begin e_mask[1] = 1'b1; e_taps[1] = m_hist[sz - m_ni]; end
    if (sz >= 2 * m_ni) begin e_mask[2] = 1'b1; e_taps[2] = m_hist[sz - 2 * m_ni]; end
    e_col = m_n % m_ni;
    e_row = m_n / m_ni;
    e_tv  = (e_row >= 2);
    e_fd  = (m_n == m_ni * m_ni - 1);
    m_n   = e_fd ? 0 : m_n + 1;
    m_hist.push_back(d);
    if (m_hist.size() > 2 * m_ni) void'(m_hist.pop_front());
  endtask

  task automatic start_frame(input bit st);
    start = 1'b0; din_valid = 1'b0; tick();
    start = 1'b1; state = st; tick();
    m_ni = st ? NI2 : NI1;
    m_n  = 0;
    m_hist.delete();
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({taps, tvalid, frame_done, col, row} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: got taps=%b tv=%b fd=%b col=%0d row=%0d, expected all 0",
               taps, tvalid, frame_done, col, row);
    end
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_layer1_ramp();
    int nvalid = 0, nfd = 0, first = -1;
    bit d;
    start_frame(1'b0);
    for (int k = 0; k < 784; k++) begin
      d = 1'(((k / 28) + (k % 28)) & 1);
      din_valid = 1'b1; din = d; tick(); model_accept(d);
      n_checks++;
      if ({taps & e_mask, tvalid, frame_done, col, row} !==
          {e_taps & e_mask, e_tv, e_fd, e_col[4:0], e_row[4:0]}) begin
        n_fail++;
        $display("FAIL ramp beat %0d: got taps=%b tv=%b fd=%b col=%0d row=%0d, expected taps=%b/%b tv=%b fd=%b col=%0d row=%0d",
                 k, taps, tvalid, frame_done, col, row, e_taps, e_mask, e_tv, e_fd, e_col, e_row);
      end
      if (tvalid) nvalid++;
      if (frame_done) nfd++;
      if (tvalid && first < 0) begin
        first = k;
        n_checks++;
        if ({row, col, taps} !== {5'd2, 5'd0, 3'b010}) begin
          n_fail++;
          $display("FAIL ramp_first_valid: got row=%0d col=%0d taps=%b, expected row=2 col=0 taps=010",
                   row, col, taps);
        end
      end
    end
    din_valid = 1'b0;
    n_checks++;
    if (nvalid !== 728) begin n_fail++; $display("FAIL ramp_valid_count: got %0d, expected 728", nvalid); end
    n_checks++;
    if (nfd !== 1) begin n_fail++; $display("FAIL ramp_done_count: got %0d, expected 1", nfd); end
    n_checks++;
    if (first !== 56) begin n_fail++; $display("FAIL ramp_first_beat: got %0d, expected 56", first); end
  endtask

  task automatic test_layer2_identity();
    int ones2 = 0, ones1 = 0, ones0 = 0;
    bit d;
    start_frame(1'b1);
    for (int k = 0; k < 144; k++) begin
      d = (k == 5 * 12 + 7);
      din_valid = 1'b1; din = d; tick(); model_accept(d);
      n_checks++;
      if ({taps & e_mask, tvalid, frame_done, col, row} !==
          {e_taps & e_mask, e_tv, e_fd, e_col[4:0], e_row[4:0]}) begin
        n_fail++;
        $display("FAIL ident beat %0d: got taps=%b tv=%b fd=%b col=%0d row=%0d, expected taps=%b/%b tv=%b fd=%b col=%0d row=%0d",
                 k, taps, tvalid, frame_done, col, row, e_taps, e_mask, e_tv, e_fd, e_col, e_row);
      end
      if (e_mask[2] && taps[2] === 1'b1) begin
        ones2++;
        n_checks++;
        if ({row, col} !== {5'd7, 5'd7}) begin
          n_fail++; $display("FAIL ident_top_pos: got row=%0d col=%0d, expected 7,7", row, col);
        end
      end
      if (e_mask[1] && taps[1] === 1'b1) ones1++;
      if (taps[0] === 1'b1) ones0++;
    end
    din_valid = 1'b0;
    n_checks++;
    if ({ones2, ones1, ones0} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL ident_ones: got top=%0d mid=%0d bot=%0d, expected 1 1 1", ones2, ones1, ones0);
    end
  endtask

  task automatic test_stall();
    int done_beat = -1;
    logic [12:0] held;
    bit d;
    start_frame(1'b1);
    for (int k = 0; k < 144; k++) begin
      d = 1'($urandom_range(0, 1));
      din_valid = 1'b1; din = d; tick(); model_accept(d);
      n_checks++;
      if ({taps & e_mask, tvalid, frame_done, col, row} !==
          {e_taps & e_mask, e_tv, e_fd, e_col[4:0], e_row[4:0]}) begin
        n_fail++;
        $display("FAIL stall beat %0d: got taps=%b tv=%b fd=%b col=%0d row=%0d, expected taps=%b/%b tv=%b fd=%b col=%0d row=%0d",
                 k, taps, tvalid, frame_done, col, row, e_taps, e_mask, e_tv, e_fd, e_col, e_row);
      end
      if (frame_done && done_beat < 0) done_beat = k;
      if (k % 5 == 4) begin
        held = {taps, col, row};
        for (int s = 0; s < 3; s++) begin
          din_valid = 1'b0; din = 1'($urandom_range(0, 1)); tick();
          n_checks++;
          if ({taps, col, row, tvalid, frame_done} !== {held, 2'b00}) begin
            n_fail++;
            $display("FAIL stall_hold beat %0d: got taps=%b col=%0d row=%0d tv=%b fd=%b, expected held %h and tv=0 fd=0",
                     k, taps, col, row, tvalid, frame_done, held);
          end
        end
      end
    end
    din_valid = 1'b0;
    n_checks++;
    if (done_beat !== 143) begin n_fail++; $display("FAIL stall_done_beat: got %0d, expected 143", done_beat); end
  endtask

  task automatic test_state_flip();
    int done_beat = -1;
    bit d;
    start_frame(1'b0);
    for (int k = 0; k < 784; k++) begin
      if (k == 100) state = 1'b1;
      d = 1'($urandom_range(0, 1));
      din_valid = 1'b1; din = d; tick(); model_accept(d);
      n_checks++;
      if ({taps & e_mask, tvalid, frame_done, col, row} !==
          {e_taps & e_mask, e_tv, e_fd, e_col[4:0], e_row[4:0]}) begin
        n_fail++;
        $display("FAIL flip beat %0d: got taps=%b tv=%b fd=%b col=%0d row=%0d, expected taps=%b/%b tv=%b fd=%b col=%0d row=%0d",
                 k, taps, tvalid, frame_done, col, row, e_taps, e_mask, e_tv, e_fd, e_col, e_row);
      end
      if (frame_done && done_beat < 0) done_beat = k;
    end
    din_valid = 1'b0;
    n_checks++;
    if (done_beat !== 783) begin n_fail++; $display("FAIL flip_done_beat: got %0d, expected 783", done_beat); end
  endtask

  task automatic test_reset_mid_frame();
    int first = -1;
    bit d;
    start_frame(1'b0);
    for (int k = 0; k <= 10 * 28 + 3; k++) begin
      din_valid = 1'b1; din = 1'($urandom_range(0, 1)); tick();
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({taps, tvalid, frame_done, col, row} !== 15'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got taps=%b tv=%b fd=%b col=%0d row=%0d, expected all 0",
               taps, tvalid, frame_done, col, row);
    end
    start = 1'b0; din_valid = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    start_frame(1'b1);
    for (int k = 0; k < 144; k++) begin
      d = 1'($urandom_range(0, 1));
      din_valid = 1'b1; din = d; tick(); model_accept(d);
      n_checks++;
      if ({taps & e_mask, tvalid, frame_done, col, row} !==
          {e_taps & e_mask, e_tv, e_fd, e_col[4:0], e_row[4:0]}) begin
        n_fail++;
        $display("FAIL postreset beat %0d: got taps=%b tv=%b fd=%b col=%0d row=%0d, expected taps=%b/%b tv=%b fd=%b col=%0d row=%0d",
                 k, taps, tvalid, frame_done, col, row, e_taps, e_mask, e_tv, e_fd, e_col, e_row);
      end
      if (tvalid && first < 0) begin
        first = k;
        n_checks++;
        if ({row, col} !== {5'd2, 5'd0}) begin
          n_fail++; $display("FAIL postreset_first_valid: got row=%0d col=%0d, expected 2,0", row, col);
        end
      end
    end
    din_valid = 1'b0;
    n_checks++;
    if (first !== 24) begin n_fail++; $display("FAIL postreset_first_beat: got %0d, expected 24", first); end
  endtask

  task automatic test_back_to_back();
    int fd0 = -1, fd1 = -1, nfd = 0, early_valid = 0;
    bit d;
    start_frame(1'b1);
    for (int k = 0; k < 288; k++) begin
      d = 1'($urandom_range(0, 1));
      din_valid = 1'b1; din = d; tick(); model_accept(d);
      n_checks++;
      if ({taps & e_mask, tvalid, frame_done, col, row} !==
          {e_taps & e_mask, e_tv, e_fd, e_col[4:0], e_row[4:0]}) begin
        n_fail++;
        $display("FAIL b2b beat %0d: got taps=%b tv=%b fd=%b col=%0d row=%0d, expected taps=%b/%b tv=%b fd=%b col=%0d row=%0d",
                 k, taps, tvalid, frame_done, col, row, e_taps, e_mask, e_tv, e_fd, e_col, e_row);
      end
      if (frame_done) begin
        nfd++;
        if (fd0 < 0) fd0 = k; else fd1 = k;
      end
      if (k >= 144 && k < 168 && tvalid) early_valid++;
    end
    n_checks++;
    if ({nfd, fd0, fd1} !== {32'd2, 32'd143, 32'd287}) begin
      n_fail++; $display("FAIL b2b_done: got count=%0d at %0d,%0d, expected 2 at 143,287", nfd, fd0, fd1);
    end
    n_checks++;
    if (early_valid !== 0) begin n_fail++; $display("FAIL b2b_early_valid: got %0d, expected 0", early_valid); end
    // dropping start clears the registered outputs on the next edge
    start = 1'b0; din = 1'b1; tick();
    n_checks++;
    if ({taps, tvalid, frame_done} !== 5'd0) begin
      n_fail++; $display("FAIL clear_on_stop: got taps=%b tv=%b fd=%b, expected 0", taps, tvalid, frame_done);
    end
    din_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_layer1_ramp();
    test_layer2_identity();
    test_stall();
    test_state_flip();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
